// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and access-check helpers for the M-stage LSU.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Word accesses need off==0, half accesses need an even offset.
   function automatic logic lsu_is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         2'b10:   return off != 2'b00;
         2'b01:   return off[0];
         default: return 1'b0;
      endcase
   endfunction

   // Loads accept LB/LH/LW/LBU/LHU; stores accept SB/SH/SW only.
   function automatic logic lsu_is_legal_f3(input logic is_load, input logic [2:0] funct3);
      if (is_load)
         return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                (funct3 == F3_LBU) || (funct3 == F3_LHU);
      return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
   endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Single-outstanding data-memory bus between the LSU (master) and memory (slave).
interface lsu_mem_stage_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic              rvalid;
   logic [31:0]       rdata;

   modport master (output req, we, addr, be, wdata, input rvalid, rdata);
   modport slave  (input req, we, addr, be, wdata, output rvalid, rdata);
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select followed by extension according to the load type.
   always_comb begin
      case (off)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  data = {24'd0, byte_sel};
         F3_LHU:  data = {16'd0, half_sel};
         default: data = rdata;
      endcase
   end
endmodule

// File: rtl/lsu_mem_stage.sv
// M-stage load/store unit: issues one memory transaction per access and
// stalls the pipeline until the response arrives.
module lsu_mem_stage
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   mem_rd_M,
   input  logic                   mem_wr_M,
   input  logic [2:0]             funct3_M,
   input  logic [31:0]            alu_out_M,
   input  logic [31:0]            store_data_M,
   lsu_mem_stage_if.master        dmem,
   output logic [31:0]            data_load_M,
   output logic                   stall_o,
   output logic                   fault_o
);
   lsu_state_e  state;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        load_q;
   logic [1:0]  off;
   logic        access;
   logic        fault;
   logic        legal;
   logic [3:0]  be_fmt;
   logic [31:0] wdata_fmt;
   logic [31:0] load_val;

   assign off = alu_out_M[1:0];

   // Access classification: both rd and wr, bad funct3 or misalignment fault.
   always_comb begin
      access = mem_rd_M ^ mem_wr_M;
      fault  = 1'b0;
      if (mem_rd_M && mem_wr_M)
         fault = 1'b1;
      else if (access)
         fault = !lsu_is_legal_f3(mem_rd_M, funct3_M) || lsu_is_misaligned(funct3_M, off);
      legal = access && !fault;
   end

   // Byte-enable and lane replication for the store data.
   always_comb begin
      case (funct3_M[1:0])
         2'b00: begin
            be_fmt    = 4'b0001 << off;
            wdata_fmt = {4{store_data_M[7:0]}};
         end
         2'b01: begin
            be_fmt    = 4'b0011 << off;
            wdata_fmt = {2{store_data_M[15:0]}};
         end
         default: begin
            be_fmt    = 4'b1111;
            wdata_fmt = store_data_M;
         end
      endcase
      if (!mem_wr_M)
         wdata_fmt = '0;
   end

   // WAIT stalls unconditionally so the stall has no path from rvalid.
   assign stall_o = rst_ni && (((state == IDLE) && legal) || (state == WAIT));
   assign fault_o = rst_ni && (state == IDLE) && fault;

   lsu_load_align u_align (
      .rdata  (dmem.rdata),
      .off    (off_q),
      .funct3 (f3_q),
      .data   (load_val)
   );

   // Transaction FSM with registered bus outputs and load capture.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         dmem.req    <= 1'b0;
         dmem.we     <= 1'b0;
         dmem.addr   <= '0;
         dmem.be     <= '0;
         dmem.wdata  <= '0;
         data_load_M <= '0;
         f3_q        <= '0;
         off_q       <= '0;
         load_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (legal) begin
                  dmem.req   <= 1'b1;
                  dmem.we    <= mem_wr_M;
                  dmem.addr  <= {alu_out_M[ADDR_W-1:2], 2'b00};
                  dmem.be    <= be_fmt;
                  dmem.wdata <= wdata_fmt;
                  f3_q       <= funct3_M;
                  off_q      <= off;
                  load_q     <= mem_rd_M;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (dmem.rvalid) begin
                  if (load_q)
                     data_load_M <= load_val;
                  dmem.req <= 1'b0;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a transaction-level reference model.
module tb_lsu_mem_stage;
   logic        clk;
   logic        rst_n;
   logic        mem_rd;
   logic        mem_wr;
   logic [2:0]  f3;
   logic [31:0] addr;
   logic [31:0] sdata;
   logic [31:0] data_load_M;
   logic        stall_o;
   logic        fault_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 0;

   // responder control
   bit          auto_resp  = 1;
   int          resp_lat   = 1;
   logic [31:0] resp_word  = '0;
   bit          man_rvalid = 0;
   logic [31:0] man_rdata  = '0;

   // captured bus values while req is high
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_we;
   bit          prev_req = 0;
   int          rise_q[$];

   // model state: 0 = no transaction, 1 = outstanding, 2 = completing
   int          m_phase;
   logic        m_req, m_we, m_isload;
   logic [31:0] m_addr, m_wdata, m_load;
   logic [3:0]  m_be;
   logic [2:0]  m_f3;
   logic [1:0]  m_off;

   lsu_mem_stage_if #(.ADDR_W(32)) dmem_bus ();

   lsu_mem_stage #(.ADDR_W(32)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .mem_rd_M     (mem_rd),
      .mem_wr_M     (mem_wr),
      .funct3_M     (f3),
      .alu_out_M    (addr),
      .store_data_M (sdata),
      .dmem         (dmem_bus),
      .data_load_M  (data_load_M),
      .stall_o      (stall_o),
      .fault_o      (fault_o)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] fn);
      return 1 << (int'(fn) % 4);
   endfunction

   function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] fn, input logic [31:0] a);
      int s;
      if (rd == wr) return 0;
      if (rd && !(fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
      if (wr && fn > 3'd2) return 0;
      s = size_of(fn);
      return (a & 32'(s - 1)) == 32'd0;
   endfunction

   function automatic logic [31:0] m_fmt_load(input logic [2:0] fn, input logic [1:0] off, input logic [31:0] rd);
      longint unsigned v, mask;
      int s;
      s    = size_of(fn);
      mask = (64'd1 << (8 * s)) - 64'd1;
      v    = (64'(rd) >> (8 * int'(off))) & mask;
      if (fn < 3'd4 && s < 4 && v >= (mask + 64'd1) / 64'd2)
         v = v | ~mask;
      return v[31:0];
   endfunction

   function automatic logic [31:0] m_fmt_wdata(input logic [2:0] fn, input logic [31:0] d);
      case (size_of(fn))
         1:       return (d & 32'hFF) * 32'h0101_0101;
         2:       return (d & 32'hFFFF) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic bit m_exp_stall();
      if (!rst_n) return 0;
      return (m_phase == 1) || (m_phase == 0 && m_legal(mem_rd, mem_wr, f3, addr));
   endfunction

   function automatic bit m_exp_fault();
      if (!rst_n) return 0;
      return (m_phase == 0) && (mem_rd || mem_wr) && !m_legal(mem_rd, mem_wr, f3, addr);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase  <= 0;
         m_req    <= 0;
         m_we     <= 0;
         m_isload <= 0;
         m_addr   <= '0;
         m_wdata  <= '0;
         m_load   <= '0;
         m_be     <= '0;
         m_f3     <= '0;
         m_off    <= '0;
      end else begin
         if (m_phase == 0) begin
            if (m_legal(mem_rd, mem_wr, f3, addr)) begin
               m_phase  <= 1;
               m_req    <= 1;
               m_we     <= mem_wr;
               m_isload <= mem_rd;
               m_addr   <= addr & ~32'd3;
               m_be     <= 4'(((1 << size_of(f3)) - 1) << int'(addr[1:0]));
               m_wdata  <= mem_wr ? m_fmt_wdata(f3, sdata) : 32'd0;
               m_f3     <= f3;
               m_off    <= addr[1:0];
            end
         end else if (m_phase == 1) begin
            if (dmem_bus.rvalid) begin
               if (m_isload) m_load <= m_fmt_load(m_f3, m_off, dmem_bus.rdata);
               m_req   <= 0;
               m_phase <= 2;
            end
         end else begin
            m_phase <= 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         chk("cyc_stall", 32'(stall_o), 32'(m_exp_stall()));
         chk("cyc_fault", 32'(fault_o), 32'(m_exp_fault()));
         chk("cyc_req", 32'(dmem_bus.req), 32'(m_req));
         chk("cyc_load", data_load_M, m_load);
         if (m_req) begin
            chk("cyc_addr", dmem_bus.addr, m_addr);
            chk("cyc_be", 32'(dmem_bus.be), 32'(m_be));
            chk("cyc_we", 32'(dmem_bus.we), 32'(m_we));
            chk("cyc_wdata", dmem_bus.wdata, m_wdata);
         end
      end
      if (dmem_bus.req && !prev_req) rise_q.push_back(cyc);
      prev_req = dmem_bus.req;
   end

   // ---------------- memory responder ----------------
   initial begin
      int cnt;
      cnt = 0;
      dmem_bus.rvalid = 0;
      dmem_bus.rdata  = '0;
      forever begin
         @(negedge clk);
         #2;
         if (auto_resp) begin
            if (dmem_bus.req && !dmem_bus.rvalid) begin
               cnt++;
               if (cnt >= resp_lat) begin
                  dmem_bus.rvalid = 1;
                  dmem_bus.rdata  = resp_word;
               end
            end else begin
               dmem_bus.rvalid = 0;
               cnt = 0;
            end
         end else begin
            dmem_bus.rvalid = man_rvalid;
            dmem_bus.rdata  = man_rdata;
            cnt = 0;
         end
      end
   end

   // One M-stage instruction; called at posedge+1, returns at posedge+1.
   task automatic do_op(input bit rd, input bit wr, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] sd, input int lat, input logic [31:0] rw,
                        output int stalls, output int faults, output int reqs, output logic [31:0] ld);
      bit done;
      done = 0; stalls = 0; faults = 0; reqs = 0;
      resp_lat = lat; resp_word = rw;
      mem_rd = rd; mem_wr = wr; f3 = fn; addr = a; sdata = sd;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (stall_o) stalls++;
         if (fault_o) faults++;
         if (dmem_bus.req) begin
            reqs++;
            cap_addr = dmem_bus.addr; cap_be = dmem_bus.be;
            cap_we = dmem_bus.we; cap_wdata = dmem_bus.wdata;
         end
         if (!m_exp_stall()) begin
            done = 1;
            break;
         end
      end
      ld = data_load_M;
      chk("op_completes", 32'(done), 32'd1);
      @(posedge clk); #1;
      mem_rd = 0; mem_wr = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, ft, rq, b2b;
      logic [31:0] ld;
      rst_n = 0; mem_rd = 0; mem_wr = 0; f3 = '0; addr = '0; sdata = '0;
      repeat (2) @(posedge clk);
      #1;
      mem_rd = 1; f3 = 3'b010; addr = 32'h100;   // legal load present during reset
      #1;
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_fault", 32'(fault_o), 32'd0);
      chk("rst_req", 32'(dmem_bus.req), 32'd0);
      chk("rst_we", 32'(dmem_bus.we), 32'd0);
      chk("rst_addr", dmem_bus.addr, 32'd0);
      chk("rst_be", 32'(dmem_bus.be), 32'd0);
      chk("rst_wdata", dmem_bus.wdata, 32'd0);
      chk("rst_load", data_load_M, 32'd0);
      mem_rd = 0;
      @(posedge clk); #1;
      rst_n = 1; chk_en = 1;
      @(posedge clk); #1;

      // LW 0x100, response two cycles after req
      do_op(1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, st, ft, rq, ld);
      chk("lw_stall_cycles", 32'(st), 32'd3);
      chk("lw_data", ld, 32'hDEAD_BEEF);
      chk("lw_be", 32'(cap_be), 32'hF);
      // LB / LBU 0x103
      do_op(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_FF7F, st, ft, rq, ld);
      chk("lb_data", ld, 32'hFFFF_FF80);
      do_op(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_FF7F, st, ft, rq, ld);
      chk("lbu_data", ld, 32'h0000_0080);
      // SH 0x202
      do_op(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 1, 32'h0, st, ft, rq, ld);
      chk("sh_addr", cap_addr, 32'h200);
      chk("sh_be", 32'(cap_be), 32'hC);
      chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
      chk("sh_we", 32'(cap_we), 32'd1);
      chk("sh_load_kept", ld, 32'h0000_0080);
      // misaligned LW
      do_op(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, st, ft, rq, ld);
      chk("mis_fault_cycles", 32'(ft), 32'd1);
      chk("mis_stall", 32'(st), 32'd0);
      chk("mis_req", 32'(rq), 32'd0);
      chk("mis_load_kept", ld, 32'h0000_0080);
      // further patterns
      do_op(1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h8001_0000, st, ft, rq, ld);
      chk("lh_data", ld, 32'hFFFF_8001);
      do_op(1, 0, 3'b101, 32'h000, 32'h0, 3, 32'h1234_F00D, st, ft, rq, ld);
      chk("lhu_data", ld, 32'h0000_F00D);
      do_op(0, 1, 3'b000, 32'h001, 32'h0000_005A, 1, 32'h0, st, ft, rq, ld);
      chk("sb_be", 32'(cap_be), 32'h2);
      chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
      do_op(0, 1, 3'b010, 32'h300, 32'h1357_9BDF, 3, 32'h0, st, ft, rq, ld);
      chk("sw_wdata", cap_wdata, 32'h1357_9BDF);
      do_op(1, 0, 3'b001, 32'h001, 32'h0, 1, 32'h0, st, ft, rq, ld);
      chk("lh_odd_fault", 32'(ft), 32'd1);
      do_op(1, 0, 3'b011, 32'h000, 32'h0, 1, 32'h0, st, ft, rq, ld);
      chk("ld_f3_011_fault", 32'(ft), 32'd1);
      do_op(0, 1, 3'b100, 32'h000, 32'h0, 1, 32'h0, st, ft, rq, ld);
      chk("st_f3_100_fault", 32'(ft), 32'd1);
      do_op(1, 1, 3'b010, 32'h000, 32'h0, 1, 32'h0, st, ft, rq, ld);
      chk("rd_wr_fault", 32'(ft), 32'd1);
      do_op(0, 0, 3'b010, 32'h000, 32'h0, 1, 32'h0, st, ft, rq, ld);
      chk("no_access_fault", 32'(ft), 32'd0);

      // reset while waiting, then a stray late response
      auto_resp = 0; man_rvalid = 0;
      mem_rd = 1; f3 = 3'b010; addr = 32'h500;
      @(negedge clk);
      @(negedge clk);
      #3 rst_n = 0;
      #1;
      chk("rstw_req", 32'(dmem_bus.req), 32'd0);
      chk("rstw_stall", 32'(stall_o), 32'd0);
      mem_rd = 0;
      @(posedge clk); #1;
      rst_n = 1;
      man_rvalid = 1; man_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      man_rvalid = 0;
      @(negedge clk);
      chk("late_rvalid_load", data_load_M, 32'd0);
      chk("late_rvalid_stall", 32'(stall_o), 32'd0);
      chk("late_rvalid_req", 32'(dmem_bus.req), 32'd0);
      auto_resp = 1;
      @(posedge clk); #1;

      // back-to-back LW then SW
      rise_q.delete();
      do_op(1, 0, 3'b010, 32'h400, 32'h0, 1, 32'hCAFE_F00D, st, ft, rq, ld);
      chk("b2b_lw_data", ld, 32'hCAFE_F00D);
      do_op(0, 1, 3'b010, 32'h404, 32'h0BAD_0BAD, 1, 32'h0, st, ft, rq, ld);
      chk("b2b_sw_addr", cap_addr, 32'h404);
      chk("b2b_req_count", 32'(rise_q.size()), 32'd2);
      b2b = (rise_q.size() == 2) ? rise_q[1] - rise_q[0] : -1;
      chk("b2b_req_spacing", 32'(b2b), 32'd3);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
